// File: rtl/teclado_emulador.sv
// 4x4 matrix-keypad responder: closes the requested switch with emulated press/release bounce,
// then drives the row lines from the scanner's column strobes as a real switch matrix would.
module teclado_emulador #(
  parameter int          BOUNCE_CYCLES = 250_000,
  parameter int          TOGGLE_CYCLES = 5_000,
  parameter int          HOLD_CYCLES   = 2_000_000,
  parameter int          GAP_CYCLES    = 1_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] fila,
  output logic       contact,
  output logic       busy,
  output logic       done
);

  localparam int MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAXP   = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
  localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int TW     = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;

  localparam logic [CW-1:0] BOUNCE_LAST = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TOG_LAST    = TW'(TOGGLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B_PRESS,
    S_HOLD,
    S_B_REL,
    S_GAP
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [TW-1:0]   r_tog, w_tog_n;
  logic [15:0]     r_lfsr, w_lfsr_n;
  logic            r_contact, w_contact_n;
  logic            r_done, w_done_n;
  logic [1:0]      r_row, w_row_n;
  logic [1:0]      r_col, w_col_n;
  logic            w_lfsr_fb;
  logic [3:0]      w_fila;

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tog     <= '0;
      r_lfsr    <= LFSR_SEED;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
      r_row     <= 2'd0;
      r_col     <= 2'd0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_tog     <= w_tog_n;
      r_lfsr    <= w_lfsr_n;
      r_contact <= w_contact_n;
      r_done    <= w_done_n;
      r_row     <= w_row_n;
      r_col     <= w_col_n;
    end
  end

  // The final bounce cycle forces the settled contact level and does not advance the LFSR,
  // even when it coincides with a toggle boundary.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt + 1'b1;
    w_tog_n     = r_tog;
    w_lfsr_n    = r_lfsr;
    w_contact_n = r_contact;
    w_done_n    = 1'b0;
    w_row_n     = r_row;
    w_col_n     = r_col;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        w_tog_n = '0;
        if (key_valid) begin
          w_row_n     = key_code[3:2];
          w_col_n     = key_code[1:0];
          w_contact_n = 1'b1;
          w_state_n   = (BOUNCE_CYCLES == 0) ? S_HOLD : S_B_PRESS;
        end
      end
      S_B_PRESS, S_B_REL: begin
        if (r_cnt == BOUNCE_LAST) begin
          w_contact_n = (r_state == S_B_PRESS);
          w_state_n   = (r_state == S_B_PRESS) ? S_HOLD : S_GAP;
          w_cnt_n     = '0;
          w_tog_n     = '0;
        end else if (r_tog == TOG_LAST) begin
          w_tog_n     = '0;
          w_contact_n = r_lfsr[0];
          w_lfsr_n    = {w_lfsr_fb, r_lfsr[15:1]};
        end else begin
          w_tog_n = r_tog + 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_n = '0;
          w_tog_n = '0;
          if (BOUNCE_CYCLES == 0) begin
            w_state_n   = S_GAP;
            w_contact_n = 1'b0;
          end else begin
            w_state_n = S_B_REL;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
          w_cnt_n   = '0;
        end
      end
      default: begin
        w_state_n   = S_IDLE;
        w_contact_n = 1'b0;
      end
    endcase
  end

  // Physical switch model: a row is pulled low only while its closed key's column is strobed.
  always_comb begin
    w_fila = 4'hF;
    if (r_contact && (col[r_col] == 1'b0)) begin
      w_fila[r_row] = 1'b0;
    end
  end

  assign fila      = w_fila;
  assign contact   = r_contact;
  assign done      = r_done;
  assign key_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_teclado_emulador.sv
// Directed bench for teclado_emulador: a no-bounce instance (dut0) and a bounce instance (dut1)
// checked cycle by cycle against hand-derived timelines and a reference LFSR.
module tb_teclado_emulador;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic       kv0, kr0, ct0, busy0, done0;
  logic [3:0] kc0, col0, fila0;
  logic       kv1, kr1, ct1, busy1, done1;
  logic [3:0] kc1, col1, fila1;

  teclado_emulador #(
    .BOUNCE_CYCLES(0), .TOGGLE_CYCLES(1), .HOLD_CYCLES(8), .GAP_CYCLES(4), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .rst(rst), .key_valid(kv0), .key_code(kc0), .key_ready(kr0),
    .col(col0), .fila(fila0), .contact(ct0), .busy(busy0), .done(done0)
  );

  teclado_emulador #(
    .BOUNCE_CYCLES(16), .TOGGLE_CYCLES(4), .HOLD_CYCLES(8), .GAP_CYCLES(4), .LFSR_SEED(16'hACE1)
  ) dut1 (
    .clk(clk), .rst(rst), .key_valid(kv1), .key_code(kc1), .key_ready(kr1),
    .col(col1), .fila(fila1), .contact(ct1), .busy(busy1), .done(done1)
  );

  // Observed/expected vectors are {contact, busy, done, key_ready, fila}.
  logic [7:0] obs, exp_v;

  task automatic test_reset();
    kv0 = 1'b0; kc0 = 4'h0; col0 = 4'h0;
    kv1 = 1'b0; kc1 = 4'h0; col1 = 4'h0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 4'hF};
    obs = {ct0, busy0, done0, kr0, fila0};
    total++;
    if (obs !== exp_v) begin
      bad++; $display("[TB] FAIL reset_dut0 got=%b exp=%b", obs, exp_v);
    end
    obs = {ct1, busy1, done1, kr1, fila1};
    total++;
    if (obs !== exp_v) begin
      bad++; $display("[TB] FAIL reset_dut1 got=%b exp=%b", obs, exp_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_bounce();
    logic [15:0] m;
    logic        p[6];
    logic        ec;
    m = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      p[i] = m[0];
      m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
    end
    col1 = 4'b1110;
    @(negedge clk); kc1 = 4'h4; kv1 = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      int j;
      @(negedge clk); kv1 = 1'b0; #1;
      j = k - 1;
      if (j <= 3)       ec = 1'b1;
      else if (j <= 15) ec = p[j / 4 - 1];
      else if (j <= 27) ec = 1'b1;
      else if (j <= 39) ec = p[3 + (j - 28) / 4];
      else              ec = 1'b0;
      exp_v = {ec, (j <= 43), (j == 44), (j >= 44), ec ? 4'b1101 : 4'hF};
      obs = {ct1, busy1, done1, kr1, fila1};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("[TB] FAIL bounce k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] scan[4];
    logic       ec;
    scan = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    @(negedge clk); kc0 = 4'h6; kv0 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk); kv0 = 1'b0; col0 = scan[(k - 1) % 4]; #1;
      ec = (k <= 8);
      exp_v = {ec, (k <= 12), (k == 13), (k == 13),
               (ec && col0 == 4'b1011) ? 4'b1101 : 4'hF};
      obs = {ct0, busy0, done0, kr0, fila0};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("[TB] FAIL scan k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_col_idle();
    col0 = 4'hF;
    @(negedge clk); kc0 = 4'h9; kv0 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk); kv0 = 1'b0; #1;
      exp_v = {(k <= 8), (k <= 12), (k == 13), (k == 13), 4'hF};
      obs = {ct0, busy0, done0, kr0, fila0};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("[TB] FAIL col_idle k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_ignore_busy();
    col0 = 4'b1011;
    @(negedge clk); kc0 = 4'h6; kv0 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        kv0 = 1'b1; kc0 = 4'hA;
      end else begin
        kv0 = 1'b0;
      end
      #1;
      exp_v = {(k <= 8), (k <= 12), (k == 13), (k == 13), (k <= 8) ? 4'b1101 : 4'hF};
      obs = {ct0, busy0, done0, kr0, fila0};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("[TB] FAIL ignore_busy k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    col0 = 4'b1011;
    @(negedge clk); kc0 = 4'h6; kv0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); kv0 = 1'b0;
    end
    #1;
    total++;
    if ({busy0, fila0} !== {1'b1, 4'b1101}) begin
      bad++; $display("[TB] FAIL pre_reset got=%b exp=%b", {busy0, fila0}, {1'b1, 4'b1101});
    end
    #1 rst = 1'b1;
    #1;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 4'hF};
    obs = {ct0, busy0, done0, kr0, fila0};
    total++;
    if (obs !== exp_v) begin
      bad++; $display("[TB] FAIL async_reset got=%b exp=%b", obs, exp_v);
    end
    #1 rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      total++;
      if ({busy0, done0} !== 2'b00) begin
        bad++; $display("[TB] FAIL no_done k=%0d got=%b exp=00", k, {busy0, done0});
      end
    end
    @(negedge clk); kc0 = 4'h3; kv0 = 1'b1; col0 = 4'b0111;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk); kv0 = 1'b0; #1;
      exp_v = {(k <= 8), (k <= 12), (k == 13), (k == 13), (k <= 8) ? 4'b1110 : 4'hF};
      obs = {ct0, busy0, done0, kr0, fila0};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("[TB] FAIL after_reset k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat[4];
    logic       ec;
    pat = '{4'b0111, 4'b1011, 4'b0100, 4'b1000};
    @(negedge clk); kc0 = 4'hF; kv0 = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (k >= 14) kv0 = 1'b0;
      col0 = pat[k % 4];
      #1;
      ec = (k <= 8) || (k >= 14 && k <= 21);
      exp_v = {ec, (k != 13 && k <= 25), (k == 13 || k == 26), (k == 13 || k >= 26),
               (ec && !col0[3]) ? 4'b0111 : 4'hF};
      obs = {ct0, busy0, done0, kr0, fila0};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("[TB] FAIL back_to_back k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_scan();
    test_col_idle();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
